// File: rtl/isa_pkg.sv
// Shared definitions for the 16-bit WISC-style decode stage:
// opcodes, control-vector bit positions, empty-field constants and the stage state enum.
package isa_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam int unsigned CB_REGWRITE  = 0;
  localparam int unsigned CB_ALUSRC    = 1;
  localparam int unsigned CB_MEMWRITE  = 2;
  localparam int unsigned CB_MEMTOREG  = 3;
  localparam int unsigned CB_MEMREAD   = 4;
  localparam int unsigned CB_BRANCH    = 5;
  localparam int unsigned CB_BRANCHREG = 6;
  localparam int unsigned CB_PCS       = 7;
  localparam int unsigned CB_HALT      = 8;
  localparam int unsigned CB_USES_RS   = 9;
  localparam int unsigned CB_USES_RT   = 10;
  localparam int unsigned CB_RS_IS_RD  = 11;
  localparam int unsigned CB_NUM       = 12;

  localparam logic [11:0] NO_SET_SIG  = 12'h000;
  localparam logic [3:0]  NO_SET_REG  = 4'h0;
  localparam logic [2:0]  NO_SET_COND = 3'b000;
  localparam logic [15:0] NOP_INSTR   = 16'h0000;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

endpackage

// File: rtl/decode_comb.sv
// Pure combinational instruction decode: instruction word to control vector,
// register addresses, branch condition and immediate.
module decode_comb
  import isa_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int SIG_W  = 12
) (
  input  logic [DATA_W-1:0] instr,
  output logic [SIG_W-1:0]  signals,
  output logic [REG_W-1:0]  rd,
  output logic [REG_W-1:0]  rs,
  output logic [REG_W-1:0]  rt,
  output logic [3:0]        opcode,
  output logic [2:0]        cond,
  output logic [DATA_W-1:0] imm
);

  logic [3:0]        op_s;
  logic [CB_NUM-1:0] sig_s;
  logic [REG_W-1:0]  rhi_s, rmid_s, rlo_s;
  logic [DATA_W-1:0] sext4_s, zext4_s, zext8_s, boff_s, two_s;

  assign op_s    = instr[15:12];
  assign rhi_s   = REG_W'(instr[11:8]);
  assign rmid_s  = REG_W'(instr[7:4]);
  assign rlo_s   = REG_W'(instr[3:0]);
  assign sext4_s = {{(DATA_W-4){instr[3]}}, instr[3:0]};
  assign zext4_s = {{(DATA_W-4){1'b0}}, instr[3:0]};
  assign zext8_s = {{(DATA_W-8){1'b0}}, instr[7:0]};
  assign boff_s  = {{(DATA_W-10){instr[8]}}, instr[8:0], 1'b0};
  assign two_s   = {{(DATA_W-2){1'b0}}, 2'b10};

  // Field extraction and control-vector generation per opcode
  always_comb begin
    sig_s  = NO_SET_SIG;
    rd     = REG_W'(NO_SET_REG);
    rs     = REG_W'(NO_SET_REG);
    rt     = REG_W'(NO_SET_REG);
    opcode = op_s;
    cond   = NO_SET_COND;
    imm    = {DATA_W{1'b0}};
    if (instr[15:0] == NOP_INSTR) begin
      opcode = 4'h0;
    end else begin
      case (op_s)
        OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
          rd = rhi_s; rs = rmid_s; rt = rlo_s;
          sig_s[CB_REGWRITE] = 1'b1;
          sig_s[CB_USES_RS]  = 1'b1;
          sig_s[CB_USES_RT]  = 1'b1;
        end
        OP_SLL, OP_SRA, OP_ROR: begin
          rd = rhi_s; rs = rmid_s; imm = zext4_s;
          sig_s[CB_REGWRITE] = 1'b1;
          sig_s[CB_ALUSRC]   = 1'b1;
          sig_s[CB_USES_RS]  = 1'b1;
        end
        OP_LW: begin
          rd = rhi_s; rs = rmid_s; imm = sext4_s;
          sig_s[CB_REGWRITE] = 1'b1;
          sig_s[CB_ALUSRC]   = 1'b1;
          sig_s[CB_MEMTOREG] = 1'b1;
          sig_s[CB_MEMREAD]  = 1'b1;
          sig_s[CB_USES_RS]  = 1'b1;
        end
        OP_SW: begin
          rt = rhi_s; rs = rmid_s; imm = sext4_s;
          sig_s[CB_ALUSRC]   = 1'b1;
          sig_s[CB_MEMWRITE] = 1'b1;
          sig_s[CB_USES_RS]  = 1'b1;
          sig_s[CB_USES_RT]  = 1'b1;
        end
        OP_LHB: begin
          rd = rhi_s; rs = rhi_s; imm = zext8_s;
          sig_s[CB_REGWRITE] = 1'b1;
          sig_s[CB_ALUSRC]   = 1'b1;
          sig_s[CB_USES_RS]  = 1'b1;
          sig_s[CB_RS_IS_RD] = 1'b1;
        end
        OP_LLB: begin
          rd = rhi_s; imm = zext8_s;
          sig_s[CB_REGWRITE] = 1'b1;
          sig_s[CB_ALUSRC]   = 1'b1;
        end
        OP_B: begin
          cond = instr[11:9]; imm = boff_s;
          sig_s[CB_BRANCH] = 1'b1;
        end
        OP_BR: begin
          cond = instr[11:9]; rs = rmid_s;
          sig_s[CB_BRANCH]    = 1'b1;
          sig_s[CB_BRANCHREG] = 1'b1;
          sig_s[CB_USES_RS]   = 1'b1;
        end
        OP_PCS: begin
          rd = rhi_s; imm = two_s;
          sig_s[CB_REGWRITE] = 1'b1;
          sig_s[CB_ALUSRC]   = 1'b1;
          sig_s[CB_PCS]      = 1'b1;
        end
        OP_HLT: begin
          sig_s[CB_HALT] = 1'b1;
        end
        default: begin
          sig_s = NO_SET_SIG;
        end
      endcase
    end
    signals = {SIG_W{1'b0}};
    signals[CB_NUM-1:0] = sig_s;
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Pipelined decode stage: valid/ready intake, load-use hazard bubbles, branch flush,
// HLT latching and the ID/EX register feeding execute.
module decode_stage_pipe
  import isa_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int SIG_W  = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIG_W-1:0]  out_signals,
  output logic [REG_W-1:0]  out_rd,
  output logic [REG_W-1:0]  out_rs,
  output logic [REG_W-1:0]  out_rt,
  output logic [3:0]        out_opcode,
  output logic [2:0]        out_cond,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc,
  output logic              halted,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [SIG_W-1:0]  dec_sig_s;
  logic [REG_W-1:0]  dec_rd_s, dec_rs_s, dec_rt_s;
  logic [3:0]        dec_op_s;
  logic [2:0]        dec_cond_s;
  logic [DATA_W-1:0] dec_imm_s;

  logic              out_valid_r;
  logic [SIG_W-1:0]  out_sig_r;
  logic [REG_W-1:0]  out_rd_r, out_rs_r, out_rt_r;
  logic [3:0]        out_op_r;
  logic [2:0]        out_cond_r;
  logic [DATA_W-1:0] out_imm_r, out_pc_r;
  logic [CNT_W-1:0]  bubble_cnt_r;

  state_e state_r, state_nxt_s;
  logic   run_s, halted_s;
  logic   hazard_s, in_ready_s, accept_s, drain_s;

  decode_comb #(.DATA_W(DATA_W), .REG_W(REG_W), .SIG_W(SIG_W)) u_decode (
    .instr   (in_instr),
    .signals (dec_sig_s),
    .rd      (dec_rd_s),
    .rs      (dec_rs_s),
    .rt      (dec_rt_s),
    .opcode  (dec_op_s),
    .cond    (dec_cond_s),
    .imm     (dec_imm_s)
  );

  // Load-use hazard: held load's destination is a source of the incoming instruction
  always_comb begin
    if (out_valid_r && out_sig_r[CB_MEMREAD] && (out_rd_r != {REG_W{1'b0}}) && in_valid) begin
      hazard_s = (dec_sig_s[CB_USES_RS] && (dec_rs_s == out_rd_r)) ||
                 (dec_sig_s[CB_USES_RT] && (dec_rt_s == out_rd_r));
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign in_ready_s = run_s && !flush && !hazard_s && (!out_valid_r || out_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign drain_s    = out_valid_r && out_ready;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: only reset leaves HALTED
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (accept_s && dec_sig_s[CB_HALT]) begin
          state_nxt_s = ST_HALTED;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALTED: state_nxt_s = ST_HALTED;
      default:   state_nxt_s = ST_RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    run_s    = 1'b0;
    halted_s = 1'b0;
    case (state_r)
      ST_RUN:    run_s    = 1'b1;
      ST_HALTED: halted_s = 1'b1;
      default: begin
        run_s    = 1'b0;
        halted_s = 1'b0;
      end
    endcase
  end

  // ID/EX register and saturating bubble counter; flush outranks everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_sig_r    <= {SIG_W{1'b0}};
      out_rd_r     <= {REG_W{1'b0}};
      out_rs_r     <= {REG_W{1'b0}};
      out_rt_r     <= {REG_W{1'b0}};
      out_op_r     <= 4'h0;
      out_cond_r   <= 3'b000;
      out_imm_r    <= {DATA_W{1'b0}};
      out_pc_r     <= {DATA_W{1'b0}};
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      out_valid_r <= 1'b0;
      out_sig_r   <= {SIG_W{1'b0}};
      out_rd_r    <= {REG_W{1'b0}};
      out_rs_r    <= {REG_W{1'b0}};
      out_rt_r    <= {REG_W{1'b0}};
      out_op_r    <= 4'h0;
      out_cond_r  <= 3'b000;
      out_imm_r   <= {DATA_W{1'b0}};
      out_pc_r    <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_sig_r   <= dec_sig_s;
      out_rd_r    <= dec_rd_s;
      out_rs_r    <= dec_rs_s;
      out_rt_r    <= dec_rt_s;
      out_op_r    <= dec_op_s;
      out_cond_r  <= dec_cond_s;
      out_imm_r   <= dec_imm_s;
      out_pc_r    <= in_pc;
    end else if (drain_s) begin
      out_valid_r <= 1'b0;
      if (hazard_s && (bubble_cnt_r != {CNT_W{1'b1}})) begin
        bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_r;
  assign out_signals = out_sig_r;
  assign out_rd      = out_rd_r;
  assign out_rs      = out_rs_r;
  assign out_rt      = out_rt_r;
  assign out_opcode  = out_op_r;
  assign out_cond    = out_cond_r;
  assign out_imm     = out_imm_r;
  assign out_pc      = out_pc_r;
  assign halted      = halted_s;
  assign bubble_cnt  = bubble_cnt_r;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Randomized scoreboard bench for decode_stage_pipe against a table-driven ISA reference model.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0, halted;
  logic [15:0] in_instr = 16'h0000, in_pc = 16'h0000, out_imm, out_pc, bubble_cnt;
  logic [11:0] out_signals;
  logic [3:0]  out_rd, out_rs, out_rt, out_opcode;
  logic [2:0]  out_cond;

  always #5 clk = ~clk;

  decode_stage_pipe #(.DATA_W(16), .REG_W(4), .SIG_W(12), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_signals(out_signals), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
    .out_opcode(out_opcode), .out_cond(out_cond), .out_imm(out_imm), .out_pc(out_pc),
    .halted(halted), .bubble_cnt(bubble_cnt)
  );

  typedef struct {
    logic [11:0] sig;
    logic [3:0]  rd, rs, rt, opc;
    logic [2:0]  cond;
    logic [15:0] imm, pc;
  } exp_t;

  // Control vector per opcode, written straight from the ISA table
  localparam logic [11:0] SIG_TBL [16] = '{
    12'h601, 12'h601, 12'h601, 12'h601, 12'h203, 12'h203, 12'h203, 12'h601,
    12'h21B, 12'h606, 12'hA03, 12'h003, 12'h020, 12'h260, 12'h083, 12'h100};

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   halted_m = 1'b0;
  int   bubbles_m = 0;

  function automatic exp_t model(input logic [15:0] ins, input logic [15:0] pc);
    exp_t e;
    int   v;
    e.sig = 12'h000; e.rd = 4'h0; e.rs = 4'h0; e.rt = 4'h0;
    e.opc = ins[15:12]; e.cond = 3'b000; e.imm = 16'h0000; e.pc = pc;
    if (ins == 16'h0000) begin
      e.opc = 4'h0;
      return e;
    end
    e.sig = SIG_TBL[ins[15:12]];
    case (ins[15:12])
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7: begin e.rd = ins[11:8]; e.rs = ins[7:4]; e.rt = ins[3:0]; end
      4'h4, 4'h5, 4'h6: begin e.rd = ins[11:8]; e.rs = ins[7:4]; e.imm = {12'h000, ins[3:0]}; end
      4'h8, 4'h9: begin
        v = int'(ins[3:0]);
        if (v > 7) v = v - 16;
        e.imm = 16'(v);
        e.rs = ins[7:4];
        if (ins[15:12] == 4'h8) e.rd = ins[11:8];
        else e.rt = ins[11:8];
      end
      4'hA: begin e.rd = ins[11:8]; e.rs = ins[11:8]; e.imm = {8'h00, ins[7:0]}; end
      4'hB: begin e.rd = ins[11:8]; e.imm = {8'h00, ins[7:0]}; end
      4'hC: begin
        v = int'(ins[8:0]);
        if (v > 255) v = v - 512;
        e.imm = 16'(v * 2);
        e.cond = ins[11:9];
      end
      4'hD: begin e.rs = ins[7:4]; e.cond = ins[11:9]; end
      4'hE: begin e.rd = ins[11:8]; e.imm = 16'd2; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every consumed output is popped from the scoreboard and compared
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output actual=valid expected=empty at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("out_signals", 32'(out_signals), 32'(e.sig));
          chk("out_rd",      32'(out_rd),      32'(e.rd));
          chk("out_rs",      32'(out_rs),      32'(e.rs));
          chk("out_rt",      32'(out_rt),      32'(e.rt));
          chk("out_opcode",  32'(out_opcode),  32'(e.opc));
          chk("out_cond",    32'(out_cond),    32'(e.cond));
          chk("out_imm",     32'(out_imm),     32'(e.imm));
          chk("out_pc",      32'(out_pc),      32'(e.pc));
        end
      end
    end
  end

  // One cycle: drive at posedge+1, check handshake/status at +2, update model after the edge
  task automatic step(input logic iv, input logic [15:0] ins, input logic [15:0] pc,
                      input logic fl, input logic ordy);
    exp_t inc;
    logic hz, er, d_acc, d_drain;
    in_valid = iv; in_instr = ins; in_pc = pc; flush = fl; out_ready = ordy;
    #1;
    inc = model(ins, pc);
    hz = 1'b0;
    if (q.size() == 1 && iv && q[0].opc == 4'h8 && q[0].sig != 12'h000 && q[0].rd != 4'h0)
      hz = (inc.sig[9] && inc.rs == q[0].rd) || (inc.sig[10] && inc.rt == q[0].rd);
    er = !halted_m && !fl && !hz && (q.size() == 0 || ordy);
    chk("in_ready",   32'(in_ready),   32'(er));
    chk("out_valid",  32'(out_valid),  32'(q.size() != 0));
    chk("halted",     32'(halted),     32'(halted_m));
    chk("bubble_cnt", 32'(bubble_cnt), 32'(bubbles_m));
    d_acc   = iv && er;
    d_drain = (q.size() != 0) && ordy && !fl;
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
    end else if (d_acc) begin
      q.push_back(inc);
      if (ins[15:12] == 4'hF) halted_m = 1'b1;
    end else if (d_drain && hz && bubbles_m < 65535) begin
      bubbles_m++;
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_instr = 16'h0000; in_pc = 16'h0000;
    rst = 1'b1;
    q.delete();
    halted_m = 1'b0;
    bubbles_m = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid",  32'(out_valid),   32'd0);
    chk("rst_halted",     32'(halted),      32'd0);
    chk("rst_bubble_cnt", 32'(bubble_cnt),  32'd0);
    chk("rst_signals",    32'(out_signals), 32'd0);
    chk("rst_pc",         32'(out_pc),      32'd0);
    chk("rst_in_ready",   32'(in_ready),    32'd1);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0]  op;
    logic [15:0] r;
    op = 4'($urandom_range(0, 14));
    if ($urandom_range(0, 3) == 0) op = 4'h8;
    r = {op, 2'b00, 2'($urandom), 2'b00, 2'($urandom), 2'b00, 2'($urandom)};
    if ($urandom_range(0, 3) == 0) r[11:0] = 12'($urandom);
    if ($urandom_range(0, 15) == 0) r = 16'h0000;
    return r;
  endfunction

  initial begin : stimulus
    logic [15:0] ins;
    logic        fl, ordy;
    do_reset();
    // ADD, then LW followed by a dependent ADD
    step(1'b1, 16'h0123, 16'h0010, 1'b0, 1'b1);
    step(1'b1, 16'h8124, 16'h0012, 1'b0, 1'b1);
    step(1'b1, 16'h0312, 16'h0014, 1'b0, 1'b1);
    step(1'b1, 16'h0312, 16'h0014, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    chk("bubble_after_lw", 32'(bubble_cnt), 32'd1);
    // Branch and NOP
    step(1'b1, 16'hC1FF, 16'h0020, 1'b0, 1'b1);
    step(1'b1, 16'h0000, 16'h0022, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    // Flush under backpressure, then flush during a hazard
    step(1'b1, 16'h0456, 16'h0030, 1'b0, 1'b0);
    step(1'b1, 16'h1789, 16'h0032, 1'b0, 1'b0);
    step(1'b1, 16'h1789, 16'h0032, 1'b1, 1'b0);
    step(1'b1, 16'h8124, 16'h0034, 1'b0, 1'b0);
    step(1'b1, 16'h0312, 16'h0036, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    chk("bubble_after_flush", 32'(bubble_cnt), 32'd1);
    // Random traffic with a reset in the middle
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      ins  = rand_instr();
      fl   = ($urandom_range(0, 19) == 0);
      ordy = fl ? 1'b0 : 1'($urandom_range(0, 3) != 0);
      step(1'($urandom_range(0, 3) != 0), ins, 16'($urandom), fl, ordy);
    end
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    // HLT: latched, intake closed, entry still drains; reset restores RUN
    step(1'b1, 16'hF000, 16'h0100, 1'b0, 1'b0);
    chk("hlt_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'h0123, 16'h0102, 1'b0, 1'(i >= 5));
    end
    do_reset();
    step(1'b1, 16'h0123, 16'h0200, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
